// File: rtl/serialize_channels.sv
// serialize_channels: captures four I/Q channel pairs per frame and emits them as an 8-word
// interleaved stream followed by one gap cycle. Define SERIALIZE_CHANNELS_PENDING_EN for a one-deep pending frame buffer.
module serialize_channels #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] i_in0,
   input  logic [DW-1:0] q_in0,
   input  logic [DW-1:0] i_in1,
   input  logic [DW-1:0] q_in1,
   input  logic [DW-1:0] i_in2,
   input  logic [DW-1:0] q_in2,
   input  logic [DW-1:0] i_in3,
   input  logic [DW-1:0] q_in3,
   input  logic          strobe_in,
   output logic [DW-1:0] stream_out,
   output logic          strobe_out,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [2:0]    idx_r;
   logic [2:0]    idx_nxt_s;
   logic [DW-1:0] frame_r [8];
   logic [DW-1:0] in_s    [8];
   logic [DW-1:0] pend_s  [8];
   logic          pend_vld_s;
   logic          pend_to_frame_s;
   logic          accept_s;
   logic          drop_s;
   logic [DW-1:0] stream_nxt_s;
   logic          strobe_nxt_s;

   assign in_s[0] = i_in0;
   assign in_s[1] = q_in0;
   assign in_s[2] = i_in1;
   assign in_s[3] = q_in1;
   assign in_s[4] = i_in2;
   assign in_s[5] = q_in2;
   assign in_s[6] = i_in3;
   assign in_s[7] = q_in3;

   // A fresh frame is taken straight into the frame register in IDLE, and in GAP when nothing is
   // pending, so back-to-back strobes nine cycles apart never overrun.
   assign accept_s = strobe_in & ((state_r == IDLE) | ((state_r == GAP) & ~pend_vld_s));

`ifdef SERIALIZE_CHANNELS_PENDING_EN
   logic [DW-1:0] pend_r [8];
   logic          pend_vld_r;
   logic          pend_load_s;

   assign pend_vld_s      = pend_vld_r;
   assign pend_to_frame_s = (state_r == GAP) & pend_vld_r;
   assign pend_load_s     = strobe_in & (((state_r == SEND) & ~pend_vld_r) | pend_to_frame_s);
   assign drop_s          = strobe_in & (state_r == SEND) & pend_vld_r;
   assign pend_s          = pend_r;

   // Pending slot: filled from live inputs while busy, drained into the frame register in GAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld_r <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            pend_r[i] <= {DW{1'b0}};
         end
      end else if (pend_load_s) begin
         pend_vld_r <= 1'b1;
         for (int i = 0; i < 8; i++) begin
            pend_r[i] <= in_s[i];
         end
      end else if (pend_to_frame_s) begin
         pend_vld_r <= 1'b0;
      end else begin
         pend_vld_r <= pend_vld_r;
      end
   end
`else
   assign pend_vld_s      = 1'b0;
   assign pend_to_frame_s = 1'b0;
   assign drop_s          = strobe_in & (state_r == SEND);

   // No pending storage: the frame-register reload path sees constant zeros
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         pend_s[i] = {DW{1'b0}};
      end
   end
`endif

   // State and word-index register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   // Next-state logic; idx names the word currently on stream_out
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = SEND;
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = IDLE;
               idx_nxt_s   = 3'd0;
            end
         end
         SEND: begin
            if (idx_r == 3'd7) begin
               state_nxt_s = GAP;
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = SEND;
               idx_nxt_s   = idx_r + 3'd1;
            end
         end
         GAP: begin
            if (accept_s || pend_to_frame_s) begin
               state_nxt_s = SEND;
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = IDLE;
               idx_nxt_s   = 3'd0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            idx_nxt_s   = 3'd0;
         end
      endcase
   end

   // Frame register: loaded only when a new frame starts, frozen while words are emitted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            frame_r[i] <= {DW{1'b0}};
         end
      end else if (accept_s) begin
         for (int i = 0; i < 8; i++) begin
            frame_r[i] <= in_s[i];
         end
      end else if (pend_to_frame_s) begin
         for (int i = 0; i < 8; i++) begin
            frame_r[i] <= pend_s[i];
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            frame_r[i] <= frame_r[i];
         end
      end
   end

   // Output decode: word 0 comes from the source being loaded so it appears one cycle after the strobe
   always_comb begin
      stream_nxt_s = stream_out;
      strobe_nxt_s = 1'b0;
      if (accept_s) begin
         stream_nxt_s = i_in0;
         strobe_nxt_s = 1'b1;
      end else if (pend_to_frame_s) begin
         stream_nxt_s = pend_s[0];
         strobe_nxt_s = 1'b1;
      end else if ((state_r == SEND) && (idx_r != 3'd7)) begin
         stream_nxt_s = frame_r[idx_r + 3'd1];
         strobe_nxt_s = 1'b1;
      end else begin
         stream_nxt_s = stream_out;
         strobe_nxt_s = 1'b0;
      end
   end

   // Registered stream outputs and overrun pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream_out <= {DW{1'b0}};
         strobe_out <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         stream_out <= stream_nxt_s;
         strobe_out <= strobe_nxt_s;
         overrun    <= drop_s;
      end
   end

   assign busy = (state_r == SEND) || (state_r == GAP);

endmodule

// File: tb/tb_serialize_channels.sv
// Self-checking bench for serialize_channels: frame-schedule reference model plus literal
// expectations; covers SERIALIZE_CHANNELS_PENDING_EN builds too.
module tb_serialize_channels;

   localparam int DW   = 16;
   localparam int NCYC = 4096;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          strobe_in;
   logic [DW-1:0] din [8];
   logic [DW-1:0] stream_out;
   logic          strobe_out;
   logic          busy;
   logic          overrun;

   int            errors;
   int            checks;
   int            cyc;
   int            last_start;
   logic [DW-1:0] model_word;
   logic          exp_stb  [NCYC];
   logic [DW-1:0] exp_word [NCYC];
   logic          exp_busy [NCYC];
   logic          exp_ovr  [NCYC];
   logic [DW-1:0] lit1 [8];
   logic [DW-1:0] lit2 [8];

   always #5 clk = ~clk;

   serialize_channels #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_in0      (din[0]),
      .q_in0      (din[1]),
      .i_in1      (din[2]),
      .q_in1      (din[3]),
      .i_in2      (din[4]),
      .q_in2      (din[5]),
      .i_in3      (din[6]),
      .q_in3      (din[7]),
      .strobe_in  (strobe_in),
      .stream_out (stream_out),
      .strobe_out (strobe_out),
      .busy       (busy),
      .overrun    (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   // Expected outputs for the current cycle, read from the frame schedule
   task automatic compare_model();
      if (exp_stb[cyc]) model_word = exp_word[cyc];
      check("strobe_out", 32'(strobe_out), 32'(exp_stb[cyc]));
      check("stream_out", 32'(stream_out), 32'(model_word));
      check("busy",       32'(busy),       32'(exp_busy[cyc]));
      check("overrun",    32'(overrun),    32'(exp_ovr[cyc]));
   endtask

   // A frame occupies 8 word cycles plus one gap; a new frame may start 9 cycles after the last
   task automatic offer();
      int s;
      s = -1;
      if (cyc + 1 >= last_start + 9) s = cyc + 1;
`ifdef SERIALIZE_CHANNELS_PENDING_EN
      else if (cyc + 1 >= last_start) s = last_start + 9;
`endif
      if (s < 0) begin
         exp_ovr[cyc + 1] = 1'b1;
      end else begin
         last_start = s;
         for (int k = 0; k < 8; k++) begin
            exp_stb[s + k]  = 1'b1;
            exp_word[s + k] = din[k];
         end
         for (int k = 0; k < 9; k++) exp_busy[s + k] = 1'b1;
      end
   endtask

   task automatic tick(input logic stb);
      compare_model();
      strobe_in = stb;
      if (stb && rst_n) offer();
      @(negedge clk);
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      for (int k = cyc; k < NCYC; k++) begin
         exp_stb[k]  = 1'b0;
         exp_busy[k] = 1'b0;
         exp_ovr[k]  = 1'b0;
      end
      last_start = -100;
      model_word = '0;
   endtask

   task automatic rand_din();
      for (int k = 0; k < 8; k++) din[k] = DW'($urandom);
   endtask

   initial begin
      int   base;
      int   p;
      logic stb;
      errors = 0;
      checks = 0;
      cyc = 0;
      last_start = -100;
      model_word = '0;
      for (int k = 0; k < NCYC; k++) begin
         exp_stb[k] = 1'b0; exp_word[k] = '0; exp_busy[k] = 1'b0; exp_ovr[k] = 1'b0;
      end
      lit1 = '{16'h0100, 16'h0101, 16'h0200, 16'h0201, 16'h0300, 16'h0301, 16'h0400, 16'h0401};
      lit2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
      rst_n = 1'b0;
      strobe_in = 1'b0;
      for (int k = 0; k < 8; k++) din[k] = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_stream", 32'(stream_out), 32'h0);
      check("reset_strobe", 32'(strobe_out), 32'h0);
      check("reset_busy",   32'(busy),       32'h0);
      check("reset_ovr",    32'(overrun),    32'h0);
      rst_n = 1'b1;
      tick(1'b0);
      tick(1'b0);

      // Single frame; live inputs scrambled while it is sent
      base = cyc;
      din = lit1;
      tick(1'b1);
      for (int n = 1; n <= 12; n++) begin
         if (n == 1) begin
            check("first_word", 32'(stream_out), 32'h0100);
            check("first_strobe", 32'(strobe_out), 32'h1);
         end
         if (n == 8) check("last_word", 32'(stream_out), 32'h0401);
         if (n == 9) begin
            check("gap_strobe", 32'(strobe_out), 32'h0);
            check("gap_busy",   32'(busy),       32'h1);
            check("gap_hold",   32'(stream_out), 32'h0401);
         end
         if (n == 10) check("idle_busy", 32'(busy), 32'h0);
         rand_din();
         tick(1'b0);
      end

      // Strobes nine cycles apart
      base = cyc;
      din = lit1;
      tick(1'b1);
      for (int n = 1; n <= 20; n++) begin
         if (n == 9) check("p9_gap", 32'(strobe_out), 32'h0);
         if (n == 10) begin
            check("p9_word0", 32'(stream_out), 32'h1111);
            check("p9_ovr",   32'(overrun),    32'h0);
         end
         if (n == 17) check("p9_word7", 32'(stream_out), 32'h8888);
         if (n == 9) din = lit2; else rand_din();
         tick(n == 9);
      end

      // Strobes at offsets 0, 3, 5
      base = cyc;
      din = lit1;
      tick(1'b1);
      for (int n = 1; n <= 22; n++) begin
`ifdef SERIALIZE_CHANNELS_PENDING_EN
         if (n == 4) check("pend_ovr4", 32'(overrun), 32'h0);
         if (n == 6) check("pend_ovr6", 32'(overrun), 32'h1);
         if (n == 10) check("pend_word0", 32'(stream_out), 32'h1111);
         if (n == 17) check("pend_word7", 32'(stream_out), 32'h8888);
`else
         if (n == 4) check("drop_ovr4", 32'(overrun), 32'h1);
         if (n == 6) check("drop_ovr6", 32'(overrun), 32'h1);
         if (n == 10) check("drop_busy", 32'(busy), 32'h0);
`endif
         if (n == 3) din = lit2; else rand_din();
         tick((n == 3) || (n == 5));
      end

      // Reset in the middle of a frame
      din = lit1;
      tick(1'b1);
      for (int n = 1; n < 4; n++) begin
         rand_din();
         tick(1'b0);
      end
      apply_reset();
      check("midrst_stream", 32'(stream_out), 32'h0);
      check("midrst_strobe", 32'(strobe_out), 32'h0);
      check("midrst_busy",   32'(busy),       32'h0);
      tick(1'b0);
      tick(1'b0);
      rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
         rand_din();
         tick(1'b0);
      end
      // Strobe on the first edge after reset release
      apply_reset();
      tick(1'b0);
      rst_n = 1'b1;
      din = lit2;
      tick(1'b1);
      check("post_rst_word0", 32'(stream_out), 32'h1111);
      for (int n = 0; n < 12; n++) begin
         rand_din();
         tick(1'b0);
      end

      // Randomized traffic at several strobe densities
      for (int seg = 0; seg < 8; seg++) begin
         case (seg)
            0: p = 3;
            1: p = 10;
            3: p = 25;
            4: p = 50;
            6: p = 100;
            default: p = 15;
         endcase
         for (int n = 0; n < 240; n++) begin
            if (seg == 5 && n == 100) apply_reset();
            if (seg == 5 && n == 103) rst_n = 1'b1;
            rand_din();
            if (seg == 2) stb = ((n % 9) == 0);
            else if (seg == 7) stb = ((n % 10) == 0) || ($urandom_range(0, 99) < 5);
            else stb = ($urandom_range(0, 99) < p);
            tick(stb);
         end
      end
      for (int n = 0; n < 20; n++) tick(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
